// File: rtl/timer_mux_disp_if.sv
// timer_mux_disp_if: control inputs and display/status outputs of timer_mux_disp
interface timer_mux_disp_if #(parameter int DIGITS = 4);
  logic start, clear, down, load;
  logic [4*DIGITS-1:0] load_val;
  logic [DIGITS-1:0] com;
  logic [7:0] seg;
  logic running, done, tc;
  modport master (output start, clear, down, load, load_val, input com, seg, running, done, tc);
  modport slave (input start, clear, down, load, load_val, output com, seg, running, done, tc);
endinterface

// File: rtl/timer_mux_disp.sv
// timer_mux_disp: BCD up/down timer with multiplexed common-anode 7-segment scan
// Optional leading-zero blanking when TIMER_LZB_EN is defined.
module timer_mux_disp #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 1
) (
  input logic clk,
  input logic reset_n,
  timer_mux_disp_if.slave bus
);
  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
  state_e state_q, state_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] com_q, com_d;
  logic [7:0] seg_q, seg_d;
  logic tc_q, tc_d;
  logic tick, blank, dp;
  logic [3:0] cur;
  function automatic logic [3:0] dmax(input int i);
    return (i % 2) ? 4'd5 : 4'd9;
  endfunction
  function automatic logic [DW-1:0] sat(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = v[4*i+:4] > dmax(i) ? dmax(i) : v[4*i+:4];
    return r;
  endfunction
  function automatic logic [DW-1:0] inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (c) begin
        c = r[4*i+:4] == dmax(i);
        r[4*i+:4] = c ? 4'd0 : r[4*i+:4] + 4'd1;
      end
    return r;
  endfunction
  function automatic logic [DW-1:0] dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (b) begin
        b = r[4*i+:4] == 4'd0;
        r[4*i+:4] = b ? dmax(i) : r[4*i+:4] - 4'd1;
      end
    return r;
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h01;
      4'd1: return 7'h4F;
      4'd2: return 7'h12;
      4'd3: return 7'h06;
      4'd4: return 7'h4C;
      4'd5: return 7'h24;
      4'd6: return 7'h20;
      4'd7: return 7'h0F;
      4'd8: return 7'h00;
      4'd9: return 7'h04;
      default: return 7'h7F;
    endcase
  endfunction
  assign tick = presc_q == PMAX;
  always_comb begin
    state_d = state_q;
    dig_d = dig_q;
    presc_d = presc_q;
    tc_d = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      dig_d = '0;
      presc_d = '0;
    end else if (bus.load && state_q != RUN) begin
      state_d = IDLE;
      dig_d = sat(bus.load_val);
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          tc_d = bus.down && dig_q == '0;
          state_d = tc_d ? DONE : RUN;
        end
        RUN: if (bus.start) state_d = PAUSE;
        else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick && !bus.down) begin
            dig_d = inc(dig_q);
            tc_d = dig_q == sat({DW{1'b1}});
          end else if (tick) begin
            // an already-zero count terminates rather than wrapping to the maximum
            dig_d = dig_q == '0 ? '0 : dec(dig_q);
            tc_d = dig_d == '0;
            state_d = tc_d ? DONE : RUN;
          end
        end
        PAUSE: if (bus.start) state_d = RUN;
        default: ;
      endcase
    end
  end
  always_comb begin
    scan_d = scan_q == SMAX ? '0 : scan_q + 1'b1;
    idx_d = scan_q != SMAX ? idx_q : idx_q == IMAX ? '0 : idx_q + 1'b1;
    cur = dig_d[{idx_d, 2'b00}+:4];
`ifdef TIMER_LZB_EN
    blank = idx_d != '0 && (dig_d >> {idx_d, 2'b00}) == '0;
`else
    blank = 1'b0;
`endif
    dp = !(DIGITS >= 4 && int'(idx_d) == 2 && (state_d != PAUSE || int'(presc_d) < TICK_DIV / 2));
    com_d = ~(DIGITS'(1) << idx_d);
    seg_d = {dp, blank ? 7'h7F : seg7(cur)};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dig_q <= '0;
      presc_q <= '0;
      scan_q <= '0;
      idx_q <= '0;
      com_q <= ~DIGITS'(1);
      seg_q <= 8'h81;
      tc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q <= dig_d;
      presc_q <= presc_d;
      scan_q <= scan_d;
      idx_q <= idx_d;
      com_q <= com_d;
      seg_q <= seg_d;
      tc_q <= tc_d;
    end
  end
  assign bus.com = com_q;
  assign bus.seg = seg_q;
  assign bus.tc = tc_q;
  assign bus.running = state_q == RUN;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_timer_mux_disp.sv
// tb_timer_mux_disp: scoreboard bench for timer_mux_disp (DIGITS=4, TICK_DIV=4, SCAN_DIV=2)
module tb_timer_mux_disp;
  typedef struct {
    string tag;
    logic [15:0] digits;
    logic dp_lit;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  timer_mux_disp_if #(.DIGITS(4)) bus ();
  timer_mux_disp #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h01;
      4'd1: return 7'h4F;
      4'd2: return 7'h12;
      4'd3: return 7'h06;
      4'd4: return 7'h4C;
      4'd5: return 7'h24;
      4'd6: return 7'h20;
      4'd7: return 7'h0F;
      4'd8: return 7'h00;
      4'd9: return 7'h04;
      default: return 7'h7F;
    endcase
  endfunction
  function automatic logic [3:0] dec7(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (enc(4'(d)) == s) return 4'(d);
    return s == 7'h7F ? 4'hF : 4'hE;
  endfunction
  // expected on-screen digits, F marking a blanked position
  function automatic logic [15:0] shown(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef TIMER_LZB_EN
    for (int i = 1; i < 4; i++) if ((d >> (4 * i)) == 16'h0) r[4*i+:4] = 4'hF;
`endif
    return r;
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic req(input logic s, input logic c, input logic l, input logic [15:0] lv);
    bus.start = s;
    bus.clear = c;
    bus.load = l;
    bus.load_val = lv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.load = 1'b0;
  endtask
  task automatic push(input string tag, input logic [15:0] d, input logic dp_lit);
    exp_t e;
    e.tag = tag;
    e.digits = d;
    e.dp_lit = dp_lit;
    sb.push_back(e);
  endtask
  task automatic read_and_check();
    logic [15:0] v;
    logic [7:0] s2;
    logic [3:0] onehot;
    logic [15:0] ev;
    exp_t e;
    v = 16'hEEEE;
    s2 = 8'hEE;
    repeat (16) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        onehot = ~(4'b0001 << i);
        if (bus.com == onehot) begin
          v[4*i+:4] = dec7(bus.seg[6:0]);
          if (i == 2) s2 = bus.seg;
        end
      end
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      ev = shown(e.digits);
      check({e.tag, "_digits"}, 32'(v), 32'(ev));
      check({e.tag, "_seg2"}, 32'(s2), 32'({~e.dp_lit, ev[11:8] == 4'hF ? 7'h7F : enc(ev[11:8])}));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [3:0] ecom;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.down = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_seg", 32'(bus.seg), 32'h81);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_tc", 32'(bus.tc), 32'd0);
    for (int k = 0; k < 8; k++) begin
      ecom = ~(4'b0001 << (k / 2));
      check("com_scan", 32'(bus.com), 32'(ecom));
      @(negedge clk);
    end
    req(1'b1, 1'b0, 1'b0, 16'h0);
    check("up_running", 32'(bus.running), 32'd1);
    cyc(3);
    check("pre_tick", 32'(dut.dig_q), 32'h0);
    cyc(1);
    check("first_tick", 32'(dut.dig_q), 32'h1);
    cyc(236);
    req(1'b1, 1'b0, 1'b0, 16'h0);
    check("pause_running", 32'(bus.running), 32'd0);
    push("up60", 16'h0100, 1'b1);
    read_and_check();
    cyc(20);
    push("frozen", 16'h0100, 1'b1);
    read_and_check();
    req(1'b1, 1'b0, 1'b0, 16'h0);
    check("resume", 32'(bus.running), 32'd1);
    cyc(2);
    req(1'b1, 1'b0, 1'b1, 16'h1234);
    check("ld_start_run", 32'(bus.running), 32'd0);
    push("ld_ignored", 16'h0100, 1'b0);
    read_and_check();
    req(1'b0, 1'b1, 1'b1, 16'h4321);
    push("clr_ld", 16'h0000, 1'b1);
    read_and_check();
    req(1'b0, 1'b0, 1'b1, 16'h5959);
    push("ld5959", 16'h5959, 1'b1);
    read_and_check();
    req(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(3);
    check("wrap_tc_before", 32'(bus.tc), 32'd0);
    cyc(1);
    check("wrap_tc", 32'(bus.tc), 32'd1);
    check("wrap_digits", 32'(dut.dig_q), 32'h0);
    check("wrap_running", 32'(bus.running), 32'd1);
    cyc(1);
    check("wrap_tc_after", 32'(bus.tc), 32'd0);
    req(1'b0, 1'b1, 1'b0, 16'h0);
    req(1'b0, 1'b0, 1'b1, 16'h0003);
    bus.down = 1'b1;
    req(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(4);
    check("down_2", 32'(dut.dig_q), 32'h2);
    cyc(4);
    check("down_1", 32'(dut.dig_q), 32'h1);
    cyc(3);
    check("down_tc_before", 32'(bus.tc), 32'd0);
    cyc(1);
    check("down_tc", 32'(bus.tc), 32'd1);
    check("down_done", 32'(bus.done), 32'd1);
    check("down_running", 32'(bus.running), 32'd0);
    cyc(1);
    check("down_tc_after", 32'(bus.tc), 32'd0);
    req(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(5);
    check("done_ignores_start", 32'(bus.done), 32'd1);
    push("done_zero", 16'h0000, 1'b1);
    read_and_check();
    req(1'b0, 1'b1, 1'b0, 16'h0);
    check("clear_done", 32'(bus.done), 32'd0);
    req(1'b1, 1'b0, 1'b0, 16'h0);
    check("zero_start_done", 32'(bus.done), 32'd1);
    check("zero_start_tc", 32'(bus.tc), 32'd1);
    req(1'b0, 1'b1, 1'b0, 16'h0);
    bus.down = 1'b0;
    req(1'b0, 1'b0, 1'b1, 16'h0C0A);
    push("sat_0c0a", 16'h0909, 1'b1);
    read_and_check();
    req(1'b0, 1'b0, 1'b1, 16'h7FCF);
    push("sat_7fcf", 16'h5959, 1'b1);
    read_and_check();
    req(1'b0, 1'b0, 1'b1, 16'h0007);
    push("lzb_0007", 16'h0007, 1'b1);
    read_and_check();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
